seq_detect_moore_p: RTL



---
 rtl/seq_detect_moore_p_if.sv | 14 +
 rtl/seq_detect_moore_p.sv | 83 ++++++++
 2 files changed

// File: rtl/seq_detect_moore_p_if.sv
// Serial-detector bus: sample enable and data in, match flag, state and match count out.
interface seq_detect_moore_p_if #(
    parameter int unsigned SW    = 3,
    parameter int unsigned CNT_W = 8
) ();
    logic             en;
    logic             in;
    logic             out;
    logic [SW-1:0]    current;
    logic [CNT_W-1:0] match_cnt;

    modport master (output en, in, input out, current, match_cnt);
    modport slave  (input en, in, output out, current, match_cnt);
endinterface

// File: rtl/seq_detect_moore_p.sv
// Parametrised Moore serial pattern detector; state is the matched prefix length,
// transitions come from a KMP table built from PATTERN at elaboration.
module seq_detect_moore_p #(
    parameter int unsigned        LEN     = 6,
    parameter logic [LEN-1:0]     PATTERN = 6'b100000,
    parameter bit                 OVERLAP = 1'b0,
    parameter int unsigned        CNT_W   = 8,
    localparam int unsigned       SW      = $clog2(LEN + 1)
) (
    input logic              clk,
    input logic              r,
    seq_detect_moore_p_if.slave bus
);

    localparam logic [SW-1:0] LenS = SW'(LEN);

    // Longest j <= k+1 such that (first k pattern bits, then b) ends with the first j pattern bits.
    function automatic int kmp_next(input int k, input logic b);
        int   res;
        int   idx;
        logic ok;
        logic sbit;
        res = 0;
        for (int j = 1; j <= int'(LEN); j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    idx  = k + 1 - j + i;
                    sbit = (idx == k) ? b : PATTERN[int'(LEN) - 1 - idx];
                    if (sbit != PATTERN[int'(LEN) - 1 - i]) ok = 1'b0;
                end
                if (ok) res = j;
            end
        end
        return res;
    endfunction

    logic [SW-1:0] nxt0 [LEN+1];
    logic [SW-1:0] nxt1 [LEN+1];

    for (genvar k = 0; k <= int'(LEN); k++) begin : g_tbl
        localparam int N0 = kmp_next(k, 1'b0);
        localparam int N1 = kmp_next(k, 1'b1);
        assign nxt0[k] = SW'(N0);
        assign nxt1[k] = SW'(N1);
    end

    logic [SW-1:0]    current_q, current_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        current_d = current_q;
        cnt_d     = cnt_q;
        if (bus.en) begin
            if (current_q > LenS) begin
                current_d = '0;
            end else if (current_q == LenS && !OVERLAP) begin
                current_d = (bus.in == PATTERN[LEN-1]) ? SW'(1) : '0;
            end else begin
                current_d = bus.in ? nxt1[current_q] : nxt0[current_q];
            end
            // Counts every entry into LEN, including LEN -> LEN.
            if (current_d == LenS && cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            current_q <= '0;
            cnt_q     <= '0;
        end else begin
            current_q <= current_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out       = (current_q == LenS);
    assign bus.current   = current_q;
    assign bus.match_cnt = cnt_q;

endmodule
